serial_adder: RTL and testbench

//   Multi-cycle, parametrised successor to the 1-bit full adder cell.

---
 rtl/add_pkg.sv | 28 ++
 rtl/serial_adder_if.sv | 33 +++
 rtl/add_slice.sv | 32 +++
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_pkg
//  Brief    : Shared types and helpers for the multi-cycle serial adder.
//  Revision : 1.0  initial release
// ============================================================================
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a step count; a single-step design still gets one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_if
//  Brief    : Operand/result valid-ready bundle for the serial adder.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Producer/consumer side of the adder.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/add_slice.sv
`default_nettype none
// ============================================================================
//  Module   : add_slice
//  Brief    : BPC-bit ripple of 1-bit full adders; also exposes the carry
//             into the slice MSB so the caller can derive signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module add_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] i_a,
    input  logic [BPC-1:0] i_b,
    input  logic           i_cin,
    output logic [BPC-1:0] o_sum,
    output logic           o_cout,
    output logic           o_cmsb
);

    logic [BPC:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < BPC; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[BPC];
    assign o_cmsb = w_c[BPC-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Brief    : Multi-cycle WIDTH-bit adder, BPC bits per clock, LSB slice
//             first, with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);

    localparam int c_STEPS = WIDTH / BPC;
    localparam int c_CW    = clog2(c_STEPS);

    if (WIDTH < 1 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of BPC");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [BPC-1:0]    w_slice_sum;
    logic              w_slice_cout;
    logic              w_slice_cmsb;
    logic [WIDTH+BPC-1:0] w_sum_cat;

    add_slice #(
        .BPC (BPC)
    ) u_slice (
        .i_a    (r_a[BPC-1:0]),
        .i_b    (r_b[BPC-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout),
        .o_cmsb (w_slice_cmsb)
    );

    assign w_last    = (r_cnt == c_CW'(c_STEPS - 1));
    assign w_accept  = bus.in_valid && w_in_ready;
    // New slice enters at the MSB end; after STEPS shifts the LSB slice sits at bit 0.
    assign w_sum_cat = {w_slice_sum, r_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_carry <= w_slice_cout;
            r_sum   <= w_sum_cat[WIDTH+BPC-1:BPC];
            r_cnt   <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_cout <= w_slice_cout;
                r_ovf  <= w_slice_cmsb ^ w_slice_cout;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Scoreboard bench for serial_adder in three configurations
//             (W8/B1, W4/B2, W8/B4) against an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    logic rnd_bp;
    logic b2b3;
    int   last_acc3;
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    logic seen1, seen2, seen3;

    serial_adder_if #(.WIDTH(8)) if1 ();
    serial_adder_if #(.WIDTH(4)) if2 ();
    serial_adder_if #(.WIDTH(8)) if3 ();

    serial_adder #(.WIDTH(8), .BPC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(4), .BPC(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    serial_adder #(.WIDTH(8), .BPC(4)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from signed range.
    function automatic exp_t ref_add(input int w, input int a, input int b, input int c, input int acc);
        exp_t e;
        int   t, full, half, sa, sb, s;
        full  = 1 << w;
        half  = full / 2;
        t     = a + b + c;
        e.sum = 8'(t % full);
        e.cout = (t >= full);
        sa    = (a >= half) ? a - full : a;
        sb    = (b >= half) ? b - full : b;
        s     = sa + sb + c;
        e.ovf = (s >= half) || (s < -half);
        e.acc = acc;
        return e;
    endfunction

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            seen1 = 1'b0;
        end else begin
            if (if1.in_valid && if1.in_ready)
                q1.push_back(ref_add(8, int'(if1.a), int'(if1.b), int'(if1.cin), cyc + 1));
            if (if1.out_valid) begin
                if (q1.size() == 0) begin
                    chk("w8b1 spurious_out_valid", 32'(if1.out_valid), 0);
                end else begin
                    if (!seen1) begin
                        seen1 = 1'b1;
                        chk("w8b1 latency", 32'(cyc - q1[0].acc), 8);
                    end
                    chk("w8b1 sum", 32'(if1.sum), 32'(q1[0].sum));
                    chk("w8b1 cout", 32'(if1.cout), 32'(q1[0].cout));
                    chk("w8b1 ovf", 32'(if1.overflow), 32'(q1[0].ovf));
                    if (if1.out_ready) begin
                        void'(q1.pop_front());
                        seen1 = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            seen2 = 1'b0;
        end else begin
            if (if2.in_valid && if2.in_ready)
                q2.push_back(ref_add(4, int'(if2.a), int'(if2.b), int'(if2.cin), cyc + 1));
            if (if2.out_valid) begin
                if (q2.size() == 0) begin
                    chk("w4b2 spurious_out_valid", 32'(if2.out_valid), 0);
                end else begin
                    if (!seen2) begin
                        seen2 = 1'b1;
                        chk("w4b2 latency", 32'(cyc - q2[0].acc), 2);
                    end
                    chk("w4b2 sum", 32'(if2.sum), 32'(q2[0].sum));
                    chk("w4b2 cout", 32'(if2.cout), 32'(q2[0].cout));
                    chk("w4b2 ovf", 32'(if2.overflow), 32'(q2[0].ovf));
                    if (if2.out_ready) begin
                        void'(q2.pop_front());
                        seen2 = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q3.delete();
            seen3 = 1'b0;
        end else begin
            if (if3.in_valid && if3.in_ready) begin
                q3.push_back(ref_add(8, int'(if3.a), int'(if3.b), int'(if3.cin), cyc + 1));
                if (b2b3 && last_acc3 >= 0)
                    chk("w8b4 accept_spacing", 32'(cyc + 1 - last_acc3), 4);
                last_acc3 = cyc + 1;
            end
            if (if3.out_valid) begin
                if (q3.size() == 0) begin
                    chk("w8b4 spurious_out_valid", 32'(if3.out_valid), 0);
                end else begin
                    if (!seen3) begin
                        seen3 = 1'b1;
                        chk("w8b4 latency", 32'(cyc - q3[0].acc), 2);
                    end
                    chk("w8b4 sum", 32'(if3.sum), 32'(q3[0].sum));
                    chk("w8b4 cout", 32'(if3.cout), 32'(q3[0].cout));
                    chk("w8b4 ovf", 32'(if3.overflow), 32'(q3[0].ovf));
                    if (if3.out_ready) begin
                        void'(q3.pop_front());
                        seen3 = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        @(posedge clk); #1;
        if1.in_valid = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (if1.in_ready || n >= 200) break;
            n++;
            @(posedge clk); #1;
            if (rnd_bp) if1.out_ready = 1'($urandom_range(0, 1));
        end
        if (n >= 200) chk("w8b1 accept_timeout", 32'(if1.in_ready), 1);
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        if (rnd_bp) if1.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain1();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((q1.size() == 0 && if1.in_ready) || n >= 200) break;
            n++;
            @(posedge clk); #1;
            if (rnd_bp) if1.out_ready = 1'($urandom_range(0, 1));
        end
        if (n >= 200) chk("w8b1 drain_timeout", 32'(q1.size()), 0);
    endtask

    task automatic send2(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n;
        @(posedge clk); #1;
        if2.in_valid = 1'b1; if2.a = a; if2.b = b; if2.cin = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (if2.in_ready || n >= 50) break;
            n++;
        end
        if (n >= 50) chk("w4b2 accept_timeout", 32'(if2.in_ready), 1);
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
    endtask

    task automatic wait_ready3();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (if3.in_ready || n >= 50) break;
            n++;
        end
        if (n >= 50) chk("w8b4 accept_timeout", 32'(if3.in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        rnd_bp = 1'b0; b2b3 = 1'b0; last_acc3 = -1;
        seen1 = 1'b0; seen2 = 1'b0; seen3 = 1'b0;
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.a = '0; if3.b = '0; if3.cin = 1'b0; if3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst w8b1 in_ready", 32'(if1.in_ready), 1);
        chk("rst w8b1 out_valid", 32'(if1.out_valid), 0);
        chk("rst w8b1 sum", 32'(if1.sum), 0);
        chk("rst w8b1 cout", 32'(if1.cout), 0);
        chk("rst w8b1 ovf", 32'(if1.overflow), 0);
        chk("rst w4b2 in_ready", 32'(if2.in_ready), 1);
        chk("rst w4b2 out_valid", 32'(if2.out_valid), 0);
        chk("rst w8b4 in_ready", 32'(if3.in_ready), 1);
        chk("rst w8b4 out_valid", 32'(if3.out_valid), 0);

        // Carry-out, signed overflow corners, all-ones with carry-in
        send1(8'hFF, 8'h01, 1'b0);
        send1(8'h7F, 8'h01, 1'b0);
        send1(8'h80, 8'h80, 1'b0);
        send1(8'hFF, 8'hFF, 1'b1);
        drain1();

        // Randomized operands with random consumer backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++)
            send1(8'($urandom), 8'($urandom), 1'($urandom));
        drain1();
        rnd_bp = 1'b0;
        @(posedge clk); #1 if1.out_ready = 1'b1;

        // Backpressure in DONE: result held, new operands ignored
        @(posedge clk); #1 if1.out_ready = 1'b0;
        send1(8'h3C, 8'h5A, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (if1.out_valid || n >= 50) break;
            n++;
        end
        if (n >= 50) chk("bp out_valid_timeout", 32'(if1.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if1.in_valid = 1'b1; if1.a = 8'($urandom); if1.b = 8'($urandom); if1.cin = 1'($urandom);
            @(negedge clk);
            chk("bp in_ready", 32'(if1.in_ready), 0);
            chk("bp out_valid_held", 32'(if1.out_valid), 1);
        end
        @(posedge clk); #1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp in_ready_after_release", 32'(if1.in_ready), 1);
        drain1();

        // Reset in the middle of RUN: result discarded
        send1(8'hAA, 8'h55, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", 32'(if1.out_valid), 0);
        chk("midrst sum", 32'(if1.sum), 0);
        chk("midrst in_ready", 32'(if1.in_ready), 1);
        repeat (15) @(posedge clk);

        // W4/B2 exhaustive
        for (int v = 0; v < 512; v++)
            send2(4'(v), 4'(v >> 4), 1'(v >> 8));
        repeat (6) @(posedge clk);

        // W8/B4 back-to-back with in_valid and out_ready held high
        @(posedge clk); #1;
        b2b3 = 1'b1;
        if3.out_ready = 1'b1;
        if3.in_valid = 1'b1; if3.a = 8'h0A; if3.b = 8'h05; if3.cin = 1'b1;
        wait_ready3();
        @(posedge clk); #1;
        if3.a = 8'hF0; if3.b = 8'h0F; if3.cin = 1'b0;
        @(negedge clk);
        wait_ready3();
        @(posedge clk); #1;
        if3.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        b2b3 = 1'b0;

        @(negedge clk);
        chk("w8b1 pending_results", 32'(q1.size()), 0);
        chk("w4b2 pending_results", 32'(q2.size()), 0);
        chk("w8b4 pending_results", 32'(q3.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
